// File: rtl/float_expand_if.sv
// Operand/result handshake bundle for float_expand.
// A transfer happens on a rising edge where valid && ready; the producer holds its payload stable while valid is high and ready is low.
interface float_expand_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [3:0]  in_exp;
  logic [5:0]  in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] dq;
  logic [15:0] dq_tc;
  logic        sat;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, dq, dq_tc, sat
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, dq, dq_tc, sat
  );
endinterface

// File: rtl/float_expand.sv
// Expands a 4-bit-exponent / 6-bit-mantissa float into a 14-bit magnitude,
// shifting one bit per cycle; results are presented in both sign-magnitude and two's complement.
module float_expand #(
  parameter int EXP_MAX = 14
) (
  input  logic              clk,
  input  logic              reset,
  float_expand_if.slave     bus,
  input  logic              scan_in0,
  input  logic              scan_in1,
  input  logic              scan_in2,
  input  logic              scan_in3,
  input  logic              scan_in4,
  input  logic              scan_enable,
  input  logic              test_mode,
  output logic              scan_out0,
  output logic              scan_out1,
  output logic              scan_out2,
  output logic              scan_out3,
  output logic              scan_out4,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  count;
  logic [19:0] acc;
  logic        sign_q;
  logic        sat_flag;
  logic [13:0] mag;
  logic        accept;
  logic        finish;

  logic unused_scan;
  assign unused_scan = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4, scan_enable, test_mode};

  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  assign accept = (state == IDLE) && bus.in_valid;
  assign finish = (state == SHIFT) && (count == 4'd0);
  assign mag    = sat_flag ? 14'h3FFF : acc[19:6];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = SHIFT;
      SHIFT:   if (count == 4'd0) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    state_dbg     = state;
  end

  // Datapath: capture, shift, and register the result only on the last SHIFT cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= 4'd0;
      acc       <= 20'd0;
      sign_q    <= 1'b0;
      sat_flag  <= 1'b0;
      bus.dq    <= 15'd0;
      bus.dq_tc <= 16'd0;
      bus.sat   <= 1'b0;
    end else if (accept) begin
      sign_q   <= bus.in_sign;
      acc      <= {14'd0, bus.in_mant};
      sat_flag <= (bus.in_exp > 4'(EXP_MAX));
      count    <= (bus.in_exp > 4'(EXP_MAX)) ? 4'(EXP_MAX) : bus.in_exp;
    end else if (state == SHIFT && count != 4'd0) begin
      acc   <= {acc[18:0], 1'b0};
      count <= count - 4'd1;
    end else if (finish) begin
      bus.dq    <= {sign_q, mag};
      bus.dq_tc <= sign_q ? (16'd0 - {2'b00, mag}) : {2'b00, mag};
      bus.sat   <= sat_flag;
    end
  end

endmodule

// File: tb/tb_float_expand.sv
// Directed and exhaustive checks of float_expand against hand-computed values and an arithmetic reference.
module tb_float_expand;
  logic clk;
  logic reset;
  logic scan_in0, scan_in1, scan_in2, scan_in3, scan_in4, scan_enable, test_mode;
  logic scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;
  logic [1:0] state_dbg;

  int n_checks;
  int n_pass;
  logic [30:0] exp_q[$];

  float_expand_if bus ();

  float_expand #(.EXP_MAX(14)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .scan_in0(scan_in0), .scan_in1(scan_in1), .scan_in2(scan_in2),
    .scan_in3(scan_in3), .scan_in4(scan_in4),
    .scan_enable(scan_enable), .test_mode(test_mode),
    .scan_out0(scan_out0), .scan_out1(scan_out1), .scan_out2(scan_out2),
    .scan_out3(scan_out3), .scan_out4(scan_out4),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) $display("FAIL %s: got %0h expected %0h", name, act, req);
    else n_pass++;
  endtask

  // Present one operand; returns outputs at first out_valid and the latency in edges (accept edge = 1).
  task automatic run_op(input logic s, input logic [3:0] e, input logic [5:0] m,
                        output logic [14:0] dq_o, output logic [15:0] tc_o,
                        output logic sat_o, output int lat);
    int guard;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    bus.in_sign = s; bus.in_exp = e; bus.in_mant = m; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_sign = ~s; bus.in_exp = 4'hF; bus.in_mant = 6'h3F;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (bus.out_valid !== 1'b1) begin
      n_checks++;
      $display("FAIL timeout: out_valid never rose for s=%0d e=%0d m=%0d", s, e, m);
    end
    dq_o = bus.dq; tc_o = bus.dq_tc; sat_o = bus.sat;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.out_ready = 0; bus.in_sign = 0; bus.in_exp = 0; bus.in_mant = 0;
    {scan_in0, scan_in1, scan_in2, scan_in3, scan_in4, scan_enable, test_mode} = '0;
    reset = 1'b1;
    #3;
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_dq", 32'(bus.dq), 0);
    chk("reset_dq_tc", 32'(bus.dq_tc), 0);
    chk("reset_sat", 32'(bus.sat), 0);
    chk("reset_scan_out", 32'({scan_out0, scan_out1, scan_out2, scan_out3, scan_out4}), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_in_ready", 32'(bus.in_ready), 1);
  endtask

  task automatic test_vectors();
    logic [14:0] d; logic [15:0] t; logic sa; int lat;
    run_op(0, 0, 32, d, t, sa, lat);
    chk("v0_dq", 32'(d), 0); chk("v0_tc", 32'(t), 0); chk("v0_sat", 32'(sa), 0); chk("v0_lat", lat, 2);
    consume();
    run_op(0, 14, 63, d, t, sa, lat);
    chk("v1_dq", 32'(d), 32'h3F00); chk("v1_tc", 32'(t), 32'h3F00); chk("v1_sat", 32'(sa), 0); chk("v1_lat", lat, 16);
    consume();
    run_op(1, 7, 40, d, t, sa, lat);
    chk("v2_dq", 32'(d), 32'h4050); chk("v2_tc", 32'(t), 32'hFFB0); chk("v2_sat", 32'(sa), 0); chk("v2_lat", lat, 9);
    consume();
    run_op(1, 15, 63, d, t, sa, lat);
    chk("v3_dq", 32'(d), 32'h7FFF); chk("v3_tc", 32'(t), 32'hC001); chk("v3_sat", 32'(sa), 1); chk("v3_lat", lat, 16);
    consume();
  endtask

  task automatic test_corner_values();
    logic [14:0] d; logic [15:0] t; logic sa; int lat;
    run_op(1, 0, 32, d, t, sa, lat);
    chk("negzero_dq", 32'(d), 32'h4000); chk("negzero_tc", 32'(t), 0);
    consume();
    run_op(0, 14, 5, d, t, sa, lat);
    chk("small_mant_dq", 32'(d), 32'h0500);
    consume();
    run_op(1, 13, 1, d, t, sa, lat);
    chk("small_neg_dq", 32'(d), 32'h4080); chk("small_neg_tc", 32'(t), 32'hFF80);
    consume();
  endtask

  task automatic test_hold();
    logic [14:0] d; logic [15:0] t; logic sa; int lat;
    run_op(0, 3, 45, d, t, sa, lat);
    chk("hold_dq0", 32'(d), 32'h0005);
    bus.in_sign = 1; bus.in_exp = 2; bus.in_mant = 50; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_dq", 32'(bus.dq), 32'h0005);
      chk("hold_out_valid", 32'(bus.out_valid), 1);
      chk("hold_in_ready", 32'(bus.in_ready), 0);
    end
    // in_valid stays high across the consume edge and must not be taken there
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("release_in_ready", 32'(bus.in_ready), 1);
    chk("release_out_valid", 32'(bus.out_valid), 0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("no_capture_in_ready", 32'(bus.in_ready), 1);
  endtask

  task automatic test_abort();
    logic [14:0] d; logic [15:0] t; logic sa; int lat;
    bool_rise: begin
      int rose;
      rose = 0;
      bus.in_sign = 0; bus.in_exp = 10; bus.in_mant = 63; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort_async_idle", 32'(bus.in_ready), 1);
      chk("abort_state", 32'(state_dbg), 0);
      @(posedge clk); #1 reset = 1'b0;
      for (int i = 0; i < 15; i++) begin
        @(posedge clk); #1;
        if (bus.out_valid === 1'b1) rose = 1;
      end
      chk("abort_no_result", rose, 0);
    end
    run_op(0, 1, 32, d, t, sa, lat);
    chk("after_abort_dq", 32'(d), 1);
    chk("after_abort_lat", lat, 3);
    consume();
  endtask

  function automatic logic [30:0] ref_model(input logic s, input int e, input int m);
    int mag;
    logic [15:0] tc;
    mag = (e > 14) ? 16383 : ((m * (1 << e)) / 64);
    tc  = s ? 16'(-mag) : 16'(mag);
    return {s, 14'(mag), tc};
  endfunction

  task automatic test_exhaustive();
    logic [14:0] d; logic [15:0] t; logic sa; int lat;
    logic [30:0] exp_v;
    for (int s = 0; s < 2; s++)
      for (int e = 0; e < 16; e++)
        for (int m = 0; m < 64; m++) begin
          exp_q.push_back(ref_model(s[0], e, m));
          run_op(s[0], 4'(e), 6'(m), d, t, sa, lat);
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          exp_v = exp_q.pop_front();
          n_checks++;
          if ({bus.dq, bus.dq_tc} !== exp_v)
            $display("FAIL exhaustive s=%0d e=%0d m=%0d: got dq=%0h tc=%0h expected dq=%0h tc=%0h",
                     s, e, m, bus.dq, bus.dq_tc, exp_v[30:16], exp_v[15:0]);
          else n_pass++;
          consume();
        end
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_vectors();
    test_corner_values();
    test_hold();
    test_abort();
    do_reset();
    test_exhaustive();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/float_expand.md
FLOAT_EXPAND -- requirements
Module: float_expand

Interface
REQ-001 SHALL have parameter EXP_MAX, default 14, the largest exponent that is expanded without saturation.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, float operand presented.
REQ-005 SHALL have port in_ready, output, 1, block can accept an operand.
REQ-006 SHALL have port in_sign, input, 1, operand sign (1 = negative).
REQ-007 SHALL have port in_exp, input, 4, operand exponent.
REQ-008 SHALL have port in_mant, input, 6, operand mantissa (normalized 1xxxxx; 100000 with exp 0 encodes zero).
REQ-009 SHALL have port out_valid, output, 1, result available.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-011 SHALL have port dq, output, 15, sign-magnitude result: bit 14 is the sign, bits 13:0 are the magnitude.
REQ-012 SHALL have port dq_tc, output, 16, two's-complement result.
REQ-013 SHALL have port sat, output, 1, result was saturated.
REQ-014 SHALL have ports scan_in0..scan_in4, scan_enable and test_mode as 1-bit inputs, and scan_out0..scan_out4 as 1-bit outputs, reserved for scan insertion; scan_out* SHALL be driven 0 in RTL.

Function
REQ-015 SHALL implement the inverse of the FLOATA encoding: magnitude = (in_mant << in_exp) >> 6, truncated, 14 bits.
REQ-016 SHALL use the states IDLE, SHIFT and DONE, with in_ready = (state == IDLE) and out_valid = (state == DONE).
REQ-017 In IDLE, SHALL capture sign, mantissa into a 20-bit accumulator, and count = min(in_exp, EXP_MAX) when in_valid is high; the state then goes to SHIFT.
REQ-018 SHALL record saturation at capture: the saturation flag is set when in_exp > EXP_MAX.
REQ-019 In SHIFT with count != 0, SHALL shift the accumulator left by 1 and decrement count, one bit per cycle.
REQ-020 In SHIFT with count == 0, SHALL register the result and go to DONE:
- magnitude = accumulator[19:6], or 14'h3FFF if the saturation flag is set;
- dq = {sign, magnitude};
- dq_tc = sign ? -{2'b0, magnitude} : {2'b0, magnitude};
- sat = saturation flag.
REQ-021 The latency from the accepting edge to out_valid high SHALL be min(in_exp, EXP_MAX) + 2 cycles.
REQ-022 In DONE, dq, dq_tc and sat SHALL be held stable until out_ready is high; on out_valid && out_ready the state returns to IDLE.
REQ-023 No operand SHALL be accepted in the same cycle a result is consumed; the maximum throughput is one operand per (exp + 3) cycles.
REQ-024 Negative zero (sign 1, magnitude 0) SHALL produce dq = 15'h4000 and dq_tc = 16'h0000.
REQ-025 A mantissa below 32 SHALL NOT be renormalized; it is expanded per REQ-015 as given.
REQ-026 in_valid while busy SHALL be ignored; inputs are sampled only on the accepting edge.
REQ-027 out_ready while not in DONE SHALL have no effect.

Reset
REQ-028 Assertion of reset SHALL immediately force, without waiting for clk:
- state = IDLE, count = 0, accumulator = 0;
- dq = 0, dq_tc = 0, sat = 0, out_valid = 0;
- scan_out* = 0.
REQ-029 After deassertion of reset, in_ready SHALL be 1.
REQ-030 Reset asserted during SHIFT or DONE SHALL abort the operation with no result ever presented.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- sign 0, exp 0, mant 32 -> 2 cycles later dq = 0, dq_tc = 0, sat = 0.
- sign 0, exp 14, mant 63 -> 16 cycles later dq = 15'h3F00 (16128), dq_tc = 16'h3F00.
- sign 1, exp 7, mant 40 -> dq = 15'h4050 (mag 80), dq_tc = 16'hFFB0, latency 9.
- sign 1, exp 15, mant 63 -> dq = 15'h7FFF, dq_tc = 16'hC001, sat = 1, latency 16.
- Hold out_ready low 5 cycles in DONE -> outputs stable, in_ready = 0; then out_ready pulse -> IDLE on the next edge.
- Reset pulse mid-SHIFT (exp 10, after 4 cycles) -> out_valid never rises; next operand sign 0, exp 1, mant 32 -> dq = 1.
REQ-032 A randomized pass SHALL compare dq and dq_tc against a reference FLOATA encode/decode model over all 2 x 16 x 64 operands, with random out_ready stalls.
